// File: rtl/chip_draw_scheduler.sv
// Round-robin scheduler for the 16x16 chip-sprite path: grants one of two
// requesters, steps the sprite ROM through 256 texels and emits aligned x/y/plot.
module chip_draw_scheduler #(
    parameter int X0      = 24,
    parameter int Y0      = 16,
    parameter int ROM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [2:0] col0,
    input  logic [2:0] row0,
    input  logic [1:0] sel0,
    output logic       ack0,
    input  logic       req1,
    input  logic [2:0] col1,
    input  logic [2:0] row1,
    input  logic [1:0] sel1,
    output logic       ack1,
    output logic       err,
    output logic [7:0] rom_addr,
    output logic [1:0] sprite_sel,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic       plot,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DRAW, DRAIN, DONE} state_t;

    state_t     state_q, state_d;
    logic       port_q, port_d;
    logic       last_grant_q, last_grant_d;
    logic [2:0] col_q, col_d;
    logic [2:0] row_q, row_d;
    logic [1:0] sel_q, sel_d;
    logic       err_q, err_d;
    logic [7:0] rom_addr_q, rom_addr_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic       plot_q, plot_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;

    logic       gnt_port;
    logic       reject;
    logic       tap_valid;
    logic [7:0] tap_addr;

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        col_d        = col_q;
        row_d        = row_q;
        sel_d        = sel_q;
        err_d        = err_q;
        rom_addr_d   = rom_addr_q;
        drain_cnt_d  = drain_cnt_q;
        gnt_port     = 1'b0;
        reject       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On contention the port that did not win last time goes first
                    gnt_port     = (req0 && req1) ? ~last_grant_q : req1;
                    port_d       = gnt_port;
                    last_grant_d = gnt_port;
                    col_d        = gnt_port ? col1 : col0;
                    row_d        = gnt_port ? row1 : row0;
                    sel_d        = gnt_port ? sel1 : sel0;
                    reject       = (col_d > 3'd6) || (row_d > 3'd5) || (sel_d == 2'd3);
                    err_d        = reject;
                    rom_addr_d   = 8'd0;
                    state_d      = reject ? DONE : DRAW;
                end
            end
            DRAW: begin
                if (rom_addr_q == 8'd255) begin
                    rom_addr_d  = 8'd0;
                    drain_cnt_d = 2'(ROM_LAT - 1);
                    state_d     = DRAIN;
                end else begin
                    rom_addr_d = rom_addr_q + 8'd1;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == 2'd0) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Texel index travels alongside the ROM read so x/y line up with the colour
    generate
        if (ROM_LAT >= 2) begin : g_stage
            logic       stage_valid_q, stage_valid_d;
            logic [7:0] stage_addr_q, stage_addr_d;

            always_comb begin
                stage_valid_d = (state_q == DRAW);
                stage_addr_d  = rom_addr_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_valid_q <= 1'b0;
                    stage_addr_q  <= 8'd0;
                end else begin
                    stage_valid_q <= stage_valid_d;
                    stage_addr_q  <= stage_addr_d;
                end
            end

            assign tap_valid = stage_valid_q;
            assign tap_addr  = stage_addr_q;
        end else begin : g_direct
            assign tap_valid = (state_q == DRAW);
            assign tap_addr  = rom_addr_q;
        end
    endgenerate

    always_comb begin
        plot_d = tap_valid;
        x_d    = x_q;
        y_d    = y_q;
        if (tap_valid) begin
            x_d = 8'(X0) + {1'b0, col_q, 4'b0000} + {4'b0000, tap_addr[3:0]};
            y_d = 7'(Y0) + {row_q, 4'b0000} + {3'b000, tap_addr[7:4]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            port_q       <= 1'b0;
            last_grant_q <= 1'b1;
            col_q        <= 3'd0;
            row_q        <= 3'd0;
            sel_q        <= 2'd0;
            err_q        <= 1'b0;
            rom_addr_q   <= 8'd0;
            drain_cnt_q  <= 2'd0;
            plot_q       <= 1'b0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            col_q        <= col_d;
            row_q        <= row_d;
            sel_q        <= sel_d;
            err_q        <= err_d;
            rom_addr_q   <= rom_addr_d;
            drain_cnt_q  <= drain_cnt_d;
            plot_q       <= plot_d;
            x_q          <= x_d;
            y_q          <= y_d;
        end
    end

    assign ack0       = (state_q == DONE) && !port_q;
    assign ack1       = (state_q == DONE) && port_q;
    assign err        = (state_q == DONE) && err_q;
    assign busy       = (state_q != IDLE);
    assign rom_addr   = rom_addr_q;
    assign sprite_sel = sel_q;
    assign x_out      = x_q;
    assign y_out      = y_q;
    assign plot       = plot_q;

endmodule
